// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampled UART receiver.
//   rx_state_t : receiver FSM states
//   DATA_BITS  : payload width
//   PRESCALE_W : width of the clocks-per-bit setting and edge counter
package uart_rx_pkg;
  localparam int DATA_BITS  = 8;
  localparam int PRESCALE_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;
endpackage

// File: rtl/data_sampling.sv
// Mid-bit 2-of-3 majority sampler.
//   clk, rst    : system clock, async active-low reset
//   RX_IN       : serial line
//   edge_cnt    : position inside the current bit (0..Prescale-1)
//   Prescale    : clocks per bit (8, 16 or 32)
//   sampled_bit : majority of the samples taken at P/2-1, P/2, P/2+1
//   sample_done : strobe at P/2+2, the first count where all three samples are held
module data_sampling
  import uart_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  sampled_bit,
  output logic                  sample_done
);
  logic [PRESCALE_W-1:0] half;
  logic [2:0]            smp;

  assign half = Prescale >> 1;

  // In IDLE the counter rests at 0, which never matches a sample point,
  // so the held samples stay valid until the next bit's first sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp <= '0;
    end else begin
      if (edge_cnt == half - 6'd1) smp[0] <= RX_IN;
      if (edge_cnt == half)        smp[1] <= RX_IN;
      if (edge_cnt == half + 6'd1) smp[2] <= RX_IN;
    end
  end

  assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign sample_done = (edge_cnt == half + 6'd2);
endmodule

// File: rtl/top.sv
// UART receiver: start + 8 data (LSB first) + optional parity + 1 stop bit.
//   clk, rst   : system clock, async active-low reset
//   RX_IN      : serial line, idles high
//   PAR_EN     : a parity bit follows the data bits
//   PAR_TYP    : 0 even, 1 odd parity
//   Prescale   : clocks per bit (8, 16 or 32)
//   P_DATA     : last error-free byte
//   data_valid : level, set on a good frame, cleared at the next start bit
module top
  import uart_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_BITS-1:0]  P_DATA,
  output logic                  data_valid
);
  rx_state_t              state, nxt;
  logic [PRESCALE_W-1:0]  edge_cnt;
  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err, smp_bit, smp_done, bit_end, start_det, par_exp;

  assign bit_end   = (edge_cnt == Prescale - 6'd1);
  assign start_det = (state == IDLE) && !RX_IN;
  assign par_exp   = PAR_TYP ? ~^shreg : ^shreg;

  data_sampling u_smp (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .edge_cnt   (edge_cnt),
    .Prescale   (Prescale),
    .sampled_bit(smp_bit),
    .sample_done(smp_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!RX_IN) nxt = START;
      // A start bit that votes high was a glitch.
      START:   if (bit_end) nxt = smp_bit ? IDLE : DATA;
      DATA:    if (bit_end && bit_cnt == 3'(DATA_BITS - 1)) nxt = PAR_EN ? PARITY : STOP;
      PARITY:  if (bit_end) nxt = STOP;
      STOP:    if (bit_end) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // The detection edge is count 0 of the start bit, so START begins at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state == IDLE) begin
      edge_cnt <= start_det ? 6'd1 : 6'd0;
      bit_cnt  <= '0;
    end else begin
      edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
      if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg      <= '0;
      par_err    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
    end else begin
      if (start_det) begin
        data_valid <= 1'b0;
        par_err    <= 1'b0;
      end
      if (smp_done) begin
        case (state)
          DATA:   shreg   <= {smp_bit, shreg[DATA_BITS-1:1]};
          PARITY: par_err <= (smp_bit != par_exp);
          STOP: begin
            // A bad frame leaves the previous byte and flag untouched.
            if (smp_bit && !par_err) begin
              P_DATA     <= shreg;
              data_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_top.sv
// Self-checking bench for the UART receiver: frames are bit-banged on RX_IN,
// good frames push their byte to a scoreboard, and a monitor pops and compares
// on every data_valid rise.
module tb_top;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       data_valid;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] last_good = 8'h00;
  logic       dv_q = 1'b0;

  top dut (
    .clk       (clk),
    .rst       (rst),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .P_DATA    (P_DATA),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every rising data_valid must match the oldest good frame.
  always @(negedge clk) begin
    if (rst && data_valid && !dv_q) begin
      chk("sb_pending", sb.size() != 0, 1);
      if (sb.size() != 0) chk("rx_byte", P_DATA, sb.pop_front());
    end
    dv_q <= data_valid;
  end

  task automatic send_frame(input logic [7:0] d, input int p, input bit pen,
                            input bit ptyp, input bit pflip, input bit stopb);
    logic pbit;
    bit   good;
    pbit = (ptyp ? ~^d : ^d) ^ pflip;
    good = stopb && !(pen && pflip);
    Prescale = p[5:0];
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    if (good) begin
      sb.push_back(d);
      last_good = d;
    end
    RX_IN = 1'b0;
    for (int i = 1; i <= p; i++) begin
      @(negedge clk);
      if (i == 1) chk("dv_drop", data_valid, 0);
    end
    for (int b = 0; b < 8; b++) begin
      RX_IN = d[b];
      repeat (p) @(negedge clk);
    end
    if (pen) begin
      RX_IN = pbit;
      repeat (p) @(negedge clk);
    end
    RX_IN = stopb;
    for (int i = 1; i <= p; i++) begin
      @(negedge clk);
      if (i == p / 2 + 2) chk("dv_early", data_valid, 0);
      if (i == p / 2 + 3) chk("dv_time", data_valid, good);
      if (i == p)         chk("p_data", P_DATA, last_good);
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pdata", P_DATA, 0);
    chk("rst_dv", data_valid, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'h45, 8, 0, 0, 0, 1);   // no parity
    send_frame(8'hA8, 16, 1, 0, 0, 1);  // even parity, good
    send_frame(8'hA8, 16, 1, 0, 1, 1);  // even parity, wrong bit
    chk("par_bad_dv", data_valid, 0);
    send_frame(8'hFF, 8, 1, 1, 0, 1);   // odd parity
    send_frame(8'h3C, 8, 0, 0, 0, 0);   // framing error
    chk("frm_bad_dv", data_valid, 0);
    send_frame(8'h5A, 8, 0, 0, 0, 1);
    repeat (3) @(negedge clk);

    // Async reset mid-idle while a byte is held
    #2 rst = 1'b0;
    #1;
    chk("rst_idle_pdata", P_DATA, 0);
    chk("rst_idle_dv", data_valid, 0);
    last_good = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Start glitch: 2-clock low pulse, then a normal frame must still work
    Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    RX_IN = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_pdata", P_DATA, 0);
    send_frame(8'h66, 8, 0, 0, 0, 1);

    // Async reset mid-frame
    RX_IN = 1'b0;
    repeat (20) @(negedge clk);
    RX_IN = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_frm_pdata", P_DATA, 0);
    chk("rst_frm_dv", data_valid, 0);
    last_good = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Back-to-back at P=32
    send_frame(8'h12, 32, 0, 0, 0, 1);
    send_frame(8'h34, 32, 0, 0, 0, 1);
    repeat (5) @(negedge clk);
    chk("b2b_pdata", P_DATA, 8'h34);
    chk("b2b_dv", data_valid, 1);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
